prefetch_width_down_32i_8o: RTL
===============================

Name: prefetch_width_down_32i_8o

Overview:
- Single-clock, first-word-fall-through width down-converter: accepts 32-bit words and emits them as 8-bit bytes.
- Uses the same en/vld handshake style as the team's prefetch FIFOs.
- Counterpart of the 8-bit-in/32-bit-out packing FIFO; used where 32-bit results are serialised back onto byte-wide streams (UART/SPI/byte DMA).
- Contains a small word buffer so the upstream can write back-to-back while the downstream drains bytes.

Parameters:
- RD_DATA_WIDTH, 8: output byte width.
- RATIO, 4: bytes per word; power of 2, ≥2. WR_DATA_WIDTH = RD_DATA_WIDTH*RATIO = 32.
- DEPTH_WIDTH, 1: word buffer holds 2**DEPTH_WIDTH words (default 2).
- MSB_FIRST, 0: 0 emits byte[7:0] first; 1 emits byte[31:24] first.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous reset, active-high.
- wr_en  input  1  write strobe; word accepted when wr_en && wr_vld.
- wr_vld  output  1  buffer can accept a word this cycle.
- wr_data  input  32  word to serialise.
- rd_en  input  1  consume strobe; byte consumed when rd_en && rd_vld.
- rd_vld  output  1  rd_data holds a valid byte.
- rd_data  output  8  current byte (fall-through: valid whenever rd_vld=1).
- rd_last  output  1  current byte is the final byte of its word.
- word_cnt  output  DEPTH_WIDTH+1  words held, including a partially drained word.

Behaviour:
- Storage:
  - 2**DEPTH_WIDTH x 32 register array.
  - wr_ptr and rd_ptr are DEPTH_WIDTH+1 bits each (extra wrap bit).
  - byte_idx counter is log2(RATIO) bits.
  - word_cnt = wr_ptr - rd_ptr, modulo 2**(DEPTH_WIDTH+1).
- Reset (async assert, release on clock edge):
  - Pointers, byte_idx, word_cnt = 0; rd_vld = 0; rd_last = 0; rd_data = 0.
  - wr_vld = 0 while rst is high; wr_vld = 1 on the first clk edge after release.
  - Array contents are don't-care.
- wr_vld is registered. It is 1 iff the next-cycle word_cnt < 2**DEPTH_WIDTH.
  - A pop in the same cycle re-opens wr_vld on the following cycle, not combinationally.
- Write: when wr_en && wr_vld, mem[wr_ptr] <= wr_data and wr_ptr increments.
  - wr_en while wr_vld=0 is ignored: no state change, no error flag.
- Read output:
  - rd_vld = (word_cnt != 0).
  - rd_data = byte byte_idx of mem[rd_ptr] when MSB_FIRST=0; byte (RATIO-1-byte_idx) when MSB_FIRST=1.
  - rd_data and rd_last are combinational from registered state. rd_data is 0 when rd_vld=0.
  - rd_last = rd_vld && (byte_idx == RATIO-1).
- Consume: on rd_en && rd_vld, byte_idx increments.
  - If byte_idx was RATIO-1, byte_idx wraps to 0 and rd_ptr increments (word pop).
  - rd_en while rd_vld=0 is ignored.
- Latency: a word written at edge N produces rd_vld=1 after edge N; its first byte is visible in the cycle after the write handshake. There is no same-cycle write-to-read bypass.
- Throughput:
  - 1 byte/cycle sustained while data is held.
  - The upstream may write 1 word per RATIO cycles indefinitely with no bubble on rd_vld.
- Simultaneous write and pop: word_cnt stays unchanged; both pointers advance.
- Full (word_cnt = 2**DEPTH_WIDTH):
  - wr_vld = 0.
  - The last-byte pop on edge N raises wr_vld after edge N.
- Empty: rd_vld = 0; byte_idx is guaranteed 0.
- Pointers wrap naturally across the array; the wrap bit distinguishes full from empty.
- Reset mid-word: the partially drained word and all buffered words are discarded. byte_idx returns to 0.

Test Plan:
- Reset then idle -> after release: wr_vld=1, rd_vld=0, word_cnt=0. Asserting rd_en changes nothing.
- Write 0x44332211 with MSB_FIRST=0, rd_en held 1 -> rd_data sequence 0x11,0x22,0x33,0x44 on 4 consecutive cycles. rd_last=1 only on 0x44. Then rd_vld=0.
- MSB_FIRST=1, write 0xA1B2C3D4 -> output sequence 0xA1,0xB2,0xC3,0xD4.
- rd_en=0, write 3 words (DEPTH_WIDTH=1) -> words 1 and 2 accepted, word_cnt=2, wr_vld=0, third write ignored. Draining 8 bytes returns only words 1 and 2. wr_vld rises the cycle after the 4th byte.
- Continuous stream: wr_en asserted every 4th cycle with incrementing words, rd_en=1 -> rd_vld never drops after the first byte, and all bytes arrive in order across pointer wrap (≥10 words).
- rst asserted after 2 of 4 bytes are consumed, with 1 extra word buffered -> immediately rd_vld=0 and word_cnt=0. A new word 0xDEADBEEF then emits 0xEF first.

Source files
------------

// File: rtl/prefetch_width_down_32i_8o_if.sv
// Byte-serialiser handshake bundle: word write side (en/vld) and byte read side (en/vld/last).
// master = upstream/downstream environment, slave = the converter.
interface prefetch_width_down_32i_8o_if #(
  parameter int unsigned RD_DATA_WIDTH = 8,
  parameter int unsigned RATIO         = 4,
  parameter int unsigned DEPTH_WIDTH   = 1
);
  localparam int unsigned WR_DATA_WIDTH = RD_DATA_WIDTH * RATIO;

  logic                     wr_en;
  logic                     wr_vld;
  logic [WR_DATA_WIDTH-1:0] wr_data;
  logic                     rd_en;
  logic                     rd_vld;
  logic [RD_DATA_WIDTH-1:0] rd_data;
  logic                     rd_last;
  logic [DEPTH_WIDTH:0]     word_cnt;

  modport master (
    output wr_en, wr_data, rd_en,
    input  wr_vld, rd_vld, rd_data, rd_last, word_cnt
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output wr_vld, rd_vld, rd_data, rd_last, word_cnt
  );
endinterface

// File: rtl/prefetch_width_down_32i_8o.sv
// First-word-fall-through width down-converter: buffers 32-bit words and emits them
// one byte per consume, LSB- or MSB-first, with a small word FIFO in front.
module prefetch_width_down_32i_8o #(
  parameter int unsigned RD_DATA_WIDTH = 8,
  parameter int unsigned RATIO         = 4,
  parameter int unsigned DEPTH_WIDTH   = 1,
  parameter bit          MSB_FIRST     = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  prefetch_width_down_32i_8o_if.slave   bus
);
  localparam int unsigned WR_DATA_WIDTH = RD_DATA_WIDTH * RATIO;
  localparam int unsigned IDX_W         = $clog2(RATIO);
  localparam int unsigned DEPTH         = 2 ** DEPTH_WIDTH;
  localparam int unsigned PTR_W         = DEPTH_WIDTH + 1;

  logic [WR_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]         byte_idx_q, byte_idx_d;
  logic                     wr_vld_q, wr_vld_d;

  logic                     push_c;
  logic                     pop_byte_c;
  logic                     last_byte_c;
  logic                     rd_vld_c;
  logic [PTR_W-1:0]         word_cnt_c;
  logic [PTR_W-1:0]         cnt_next_c;
  logic [IDX_W-1:0]         sel_c;
  logic [WR_DATA_WIDTH-1:0] head_word_c;
  logic [RD_DATA_WIDTH-1:0] head_bytes_c [RATIO];

  // Handshakes and next-state pointer arithmetic
  always_comb begin
    word_cnt_c  = wr_ptr_q - rd_ptr_q;
    rd_vld_c    = (word_cnt_c != '0);
    push_c      = bus.wr_en && wr_vld_q;
    pop_byte_c  = bus.rd_en && rd_vld_c;
    last_byte_c = (byte_idx_q == IDX_W'(RATIO - 1));

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_idx_d = byte_idx_q;

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_byte_c) begin
      byte_idx_d = byte_idx_q + IDX_W'(1);
      if (last_byte_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end

    // Registered space flag looks at the post-edge occupancy, so a pop reopens it one cycle later
    cnt_next_c = wr_ptr_d - rd_ptr_d;
    wr_vld_d   = (cnt_next_c < PTR_W'(DEPTH));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_idx_q <= '0;
      wr_vld_q   <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_idx_q <= byte_idx_d;
      wr_vld_q   <= wr_vld_d;
    end
  end

  // Word storage carries no reset; unread entries are never observable
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= bus.wr_data;
    end
  end

  // Byte select from the head word
  always_comb begin
    head_word_c = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
    for (int i = 0; i < int'(RATIO); i++) begin
      head_bytes_c[i] = head_word_c[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
    end
    sel_c = MSB_FIRST ? (IDX_W'(RATIO - 1) - byte_idx_q) : byte_idx_q;
  end

  assign bus.wr_vld   = wr_vld_q;
  assign bus.rd_vld   = rd_vld_c;
  assign bus.rd_data  = rd_vld_c ? head_bytes_c[sel_c] : '0;
  assign bus.rd_last  = rd_vld_c && last_byte_c;
  assign bus.word_cnt = word_cnt_c;
endmodule
